// File: rtl/keypad_matrix_scan.sv
// 4x4 active-low keypad scanner: column walk, press/release debounce, one strobe per press.
// Optional build macro KEY_REPEAT_EN adds typematic repeat strobes while a key is held.
module keypad_matrix_scan #(
  parameter int SCAN_DIV     = 1000,
  parameter int DEB_TICKS    = 4,
  parameter int REPEAT_DELAY = 32,
  parameter int REPEAT_RATE  = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] code,
  output logic       keydown,
  output logic       key_pulse,
  output logic       scan_tick
);

  localparam int PW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

  typedef enum logic [1:0] {
    S_SCAN,
    S_PRESS_DB,
    S_HELD,
    S_RELEASE_DB
  } state_e;

  if (SCAN_DIV < 2 || DEB_TICKS < 1 || DEB_TICKS > 15 ||
      REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_bad_params
    $error("keypad_matrix_scan: parameter out of range");
  end

  logic [3:0]    row_meta_q, row_sync_q;
  logic [PW-1:0] presc_q;
  logic          tick;

  state_e     state_q, state_d;
  logic [1:0] col_idx_q, col_idx_d;
  logic [1:0] row_idx_q, row_idx_d;
  logic [3:0] deb_q, deb_d;
  logic [3:0] code_q, code_d;
  logic       keydown_q, keydown_d;
  logic       pulse_q, pulse_d;
  logic [1:0] first_low;
  logic       row_hit;
  logic       deb_done;

  // Idle rows read high through the pull-ups, so the synchroniser resets to all-ones.
  // NOTE: sequential state is written with non-blocking (<=) only, so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      row_meta_q <= 4'hF;
      row_sync_q <= 4'hF;
    end else begin
      row_meta_q <= row;
      row_sync_q <= row_meta_q;
    end
  end

  assign tick = (presc_q == PW'(SCAN_DIV - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc_q <= '0;
    end else if (tick) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_q + PW'(1);
    end
  end

  // Lowest-numbered low row wins when several rows are pulled down together.
  always_comb begin
    first_low = 2'd3;
    if (!row_sync_q[0])      first_low = 2'd0;
    else if (!row_sync_q[1]) first_low = 2'd1;
    else if (!row_sync_q[2]) first_low = 2'd2;
  end

  assign row_hit  = ~row_sync_q[row_idx_q];
  assign deb_done = (deb_q == 4'(DEB_TICKS - 1));

`ifdef KEY_REPEAT_EN
  localparam int REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RW      = $clog2(REP_MAX + 1);

  logic [RW-1:0] rep_cnt_q, rep_cnt_d;
  logic          rep_first_q, rep_first_d;
`endif

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    col_idx_d = col_idx_q;
    row_idx_d = row_idx_q;
    deb_d     = deb_q;
    code_d    = code_q;
    keydown_d = keydown_q;
    pulse_d   = 1'b0;
`ifdef KEY_REPEAT_EN
    rep_cnt_d   = rep_cnt_q;
    rep_first_d = rep_first_q;
`endif
    if (tick) begin
      case (state_q)
        S_SCAN: begin
          if (row_sync_q == 4'hF) begin
            col_idx_d = col_idx_q + 2'd1;
          end else begin
            row_idx_d = first_low;
            deb_d     = '0;
            state_d   = S_PRESS_DB;
          end
        end
        S_PRESS_DB: begin
          if (!row_hit) begin
            col_idx_d = col_idx_q + 2'd1;
            state_d   = S_SCAN;
          end else if (deb_done) begin
            code_d    = {row_idx_q, col_idx_q};
            keydown_d = 1'b1;
            pulse_d   = 1'b1;
            deb_d     = '0;
            state_d   = S_HELD;
`ifdef KEY_REPEAT_EN
            rep_cnt_d   = '0;
            rep_first_d = 1'b1;
`endif
          end else begin
            deb_d = deb_q + 4'd1;
          end
        end
        S_HELD: begin
          if (!row_hit) begin
            deb_d   = '0;
            state_d = S_RELEASE_DB;
          end else begin
`ifdef KEY_REPEAT_EN
            if (rep_first_q && rep_cnt_q == RW'(REPEAT_DELAY - 1)) begin
              pulse_d     = 1'b1;
              rep_cnt_d   = '0;
              rep_first_d = 1'b0;
            end else if (!rep_first_q && rep_cnt_q == RW'(REPEAT_RATE - 1)) begin
              pulse_d   = 1'b1;
              rep_cnt_d = '0;
            end else begin
              rep_cnt_d = rep_cnt_q + RW'(1);
            end
`endif
          end
        end
        S_RELEASE_DB: begin
          if (row_hit) begin
            state_d = S_HELD;
          end else if (deb_done) begin
            keydown_d = 1'b0;
            deb_d     = '0;
            state_d   = S_SCAN;
          end else begin
            deb_d = deb_q + 4'd1;
          end
        end
        default: state_d = S_SCAN;
      endcase
    end
  end

  // NOTE: only control state is reset here; there is no storage array that would need clearing.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_SCAN;
      col_idx_q <= '0;
      row_idx_q <= '0;
      deb_q     <= '0;
      code_q    <= '0;
      keydown_q <= 1'b0;
      pulse_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      col_idx_q <= col_idx_d;
      row_idx_q <= row_idx_d;
      deb_q     <= deb_d;
      code_q    <= code_d;
      keydown_q <= keydown_d;
      pulse_q   <= pulse_d;
    end
  end

`ifdef KEY_REPEAT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rep_cnt_q   <= '0;
      rep_first_q <= 1'b1;
    end else begin
      rep_cnt_q   <= rep_cnt_d;
      rep_first_q <= rep_first_d;
    end
  end
`endif

  assign col       = ~(4'b0001 << col_idx_q);
  assign code      = code_q;
  assign keydown   = keydown_q;
  assign key_pulse = pulse_q;
  assign scan_tick = tick;

endmodule

// File: doc/keypad_matrix_scan.md
KEYPAD_MATRIX_SCAN -- requirements
Module: keypad_matrix_scan

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 1000: clk cycles per scan tick (>=2).
REQ-002 SHALL have parameter DEB_TICKS, default 4: consecutive stable scan ticks that qualify a press or release (1..15).
REQ-003 SHALL have parameter REPEAT_DELAY, default 32: scan ticks from press to first repeat (KEY_REPEAT_EN only).
REQ-004 SHALL have parameter REPEAT_RATE, default 8: scan ticks between repeats (KEY_REPEAT_EN only).
REQ-005 SHALL have port clk, input, 1: system clock.
REQ-006 SHALL have port rst, input, 1: reset, asynchronous, active-low.
REQ-007 SHALL have port row, input, 4: matrix rows, active-low, externally pulled up, asynchronous to clk.
REQ-008 SHALL have port col, output, 4: column drive, active-low, at most one bit low at any time.
REQ-009 SHALL have port code, output, 4: key code = {row_idx[1:0], col_idx[1:0]}.
REQ-010 SHALL have port keydown, output, 1: debounced level, high while a key is held.
REQ-011 SHALL have port key_pulse, output, 1: one-clk strobe per accepted press (and per repeat).
REQ-012 SHALL have port scan_tick, output, 1: one-clk strobe every SCAN_DIV cycles, usable by display multiplexers.

Function
REQ-013 SHALL pass row through a 2-flop synchroniser before any use.
REQ-014 SHALL count clk with a prescaler wrapping at SCAN_DIV-1; scan_tick high in the wrap cycle only.
REQ-015 SHALL implement states SCAN, PRESS_DB, HELD, RELEASE_DB.
REQ-016 SCAN: on each scan_tick, if synchronised row == 4'hF, advance col_idx (0->1->2->3->0) and drive col = ~(1<<col_idx); else latch row_idx, freeze col_idx, clear debounce count, go PRESS_DB.
REQ-017 Multiple rows low: lowest row index wins.
REQ-018 PRESS_DB: on each scan_tick, same row bit low increments count, otherwise return to SCAN (column advances); count reaching DEB_TICKS goes HELD.
REQ-019 On entry to HELD: code updates to {row_idx, col_idx}, keydown rises, key_pulse high exactly one clk, all in the same cycle.
REQ-020 HELD: column stays frozen; latched row bit high at a scan_tick goes RELEASE_DB with count cleared.
REQ-021 RELEASE_DB: DEB_TICKS consecutive ticks high -> keydown falls, go SCAN; any tick low -> back to HELD, no new key_pulse.
REQ-022 code SHALL change only on entry to HELD and hold its value after release.
REQ-023 A second key pressed while HELD SHALL be ignored; it is scanned only after release completes.
REQ-024 Press-to-key_pulse latency SHALL be at most (4+DEB_TICKS+1)*SCAN_DIV+3 clk.

Reset
REQ-025 Asserting rst SHALL asynchronously force col=4'b1110, col_idx=0, code=0, keydown=0, key_pulse=0, scan_tick=0, prescaler=0, counts=0, state SCAN.
REQ-026 rst asserted mid-press SHALL drop keydown immediately; a key still held after reset release SHALL be re-debounced and produce a fresh key_pulse.

Configuration
REQ-027 Macro KEY_REPEAT_EN defined: in HELD, key_pulse SHALL also fire after REPEAT_DELAY scan ticks, then every REPEAT_RATE ticks; repeat counter restarts on entry to HELD and freezes during RELEASE_DB.
REQ-028 Macro KEY_REPEAT_EN undefined: exactly one key_pulse per press; no repeat logic synthesised.

Verification
REQ-029 SCAN_DIV=4, no key: col cycles E,D,B,7 every 4 clk; scan_tick every 4th clk; keydown=0 throughout.
REQ-030 SCAN_DIV=4, DEB_TICKS=4, row[1] low while col=4'b1011: code=4'h6, keydown=1, one key_pulse within 23 clk; release -> keydown=0 after 4 ticks, code stays 6.
REQ-031 Bounce: row toggles low/high every tick for 10 ticks then settles low -> exactly one key_pulse, none during bounce.
REQ-032 Rows 0 and 2 low together on col 1 -> code=4'h1.
REQ-033 Key held, rst pulsed low 3 clk -> keydown=0 immediately; after release of rst, new key_pulse with same code.
REQ-034 KEY_REPEAT_EN, REPEAT_DELAY=32, REPEAT_RATE=8, key held 64 ticks -> pulses at ticks 0,32,40,48,56,64 after HELD entry; without macro, one pulse.
